// File: rtl/branch_comp_pkg.sv
// Shared definitions for the iterative branch comparator: funct3 codes,
// FSM state type and the branch-condition decode.
package branch_comp_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_illegal(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
      logic taken;
      taken = 1'b0;
      case (f3)
         F3_BEQ:           taken = eq;
         F3_BNE:           taken = !eq;
         F3_BLT, F3_BLTU:  taken = lt;
         F3_BGE, F3_BGEU:  taken = !lt;
         default:          taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// One CHUNK-bit slice comparison. For the top chunk of a signed compare the
// sign bits are flipped so an unsigned compare yields the signed ordering.
module branch_chunk_cmp #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             signed_top,
   output logic             lt,
   output logic             eq
);

   logic [CHUNK-1:0] mask;
   logic [CHUNK-1:0] a_adj;
   logic [CHUNK-1:0] b_adj;

   always_comb begin
      mask            = '0;
      mask[CHUNK-1]   = signed_top;
      a_adj           = a ^ mask;
      b_adj           = b ^ mask;
      lt              = a_adj < b_adj;
      eq              = a_adj == b_adj;
   end

endmodule

// File: rtl/branch_comp_seq.sv
// Iterative branch comparator: walks the operands one chunk per cycle from
// the MSB end, stops at the first differing chunk, returns eq/lt/taken.
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high; in_ready is high only in IDLE, out_valid only in DONE.
module branch_comp_seq
   import branch_comp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic [2:0]       funct3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             br_eq,
   output logic             br_lt,
   output logic             br_taken,
   output logic             br_illegal,
   output state_t           fsm_state
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_t                       state;
   state_t                       state_nxt;
   logic [NCHUNK-1:0][CHUNK-1:0] a_q;
   logic [NCHUNK-1:0][CHUNK-1:0] b_q;
   logic [2:0]                   f3_q;
   logic [IDXW-1:0]              idx;
   logic                         signed_top;
   logic                         c_lt;
   logic                         c_eq;
   logic                         cmp_done;

   always_comb begin
      signed_top = !f3_q[1] && (idx == IDXW'(NCHUNK - 1));
      cmp_done   = !c_eq || (idx == '0);
   end

   branch_chunk_cmp #(.CHUNK(CHUNK)) u_chunk (
      .a          (a_q[idx]),
      .b          (b_q[idx]),
      .signed_top (signed_top),
      .lt         (c_lt),
      .eq         (c_eq)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!flush && in_valid) state_nxt = CMP;
         CMP: begin
            if (flush)         state_nxt = IDLE;
            else if (cmp_done) state_nxt = DONE;
         end
         DONE: if (flush || out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      fsm_state = state;
   end

   // Operand latch, chunk index and result registers
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         idx        <= '0;
         br_eq      <= 1'b0;
         br_lt      <= 1'b0;
         br_taken   <= 1'b0;
         br_illegal <= 1'b0;
         if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            f3_q <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q  <= data_a;
                  b_q  <= data_b;
                  f3_q <= funct3;
                  idx  <= IDXW'(NCHUNK - 1);
               end
            end
            CMP: begin
               if (cmp_done) begin
                  br_eq      <= c_eq;
                  br_lt      <= !c_eq && c_lt;
                  br_taken   <= branch_taken(f3_q, c_eq, !c_eq && c_lt);
                  br_illegal <= is_illegal(f3_q);
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Self-checking bench for branch_comp_seq (WIDTH=32, CHUNK=8): directed and
// random operations checked through an expected-result queue.
module tb_branch_comp_seq;
   import branch_comp_pkg::*;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int W      = 12;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic [2:0]       funct3;
   logic             out_valid;
   logic             out_ready;
   logic             br_eq;
   logic             br_lt;
   logic             br_taken;
   logic             br_illegal;
   state_t           fsm_state;

   int tests_run;
   int tests_failed;
   logic [W-1:0] exp_q[$];

   branch_comp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_a     (data_a),
      .data_b     (data_b),
      .funct3     (funct3),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .br_eq      (br_eq),
      .br_lt      (br_lt),
      .br_taken   (br_taken),
      .br_illegal (br_illegal),
      .fsm_state  (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected result: {chunks examined, eq, lt, taken, illegal}
   function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic [2:0] f3);
      logic eq, lt, tk, ill;
      int   k;
      logic [WIDTH-1:0] sa, sb;
      eq  = (a == b);
      lt  = f3[1] ? (a < b) : ($signed(a) < $signed(b));
      ill = (f3 == 3'b010) || (f3 == 3'b011);
      case (f3)
         3'b000:         tk = eq;
         3'b001:         tk = !eq;
         3'b100, 3'b110: tk = lt;
         3'b101, 3'b111: tk = !lt;
         default:        tk = 1'b0;
      endcase
      k = NCHUNK;
      for (int i = NCHUNK - 1; i >= 0; i--) begin
         sa = a >> (i * CHUNK);
         sb = b >> (i * CHUNK);
         if (sa[CHUNK-1:0] != sb[CHUNK-1:0]) begin
            k = NCHUNK - i;
            break;
         end
      end
      return {k[7:0], eq, lt, tk, ill};
   endfunction

   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] f3);
      @(negedge clk);
      check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
      data_a   = a;
      data_b   = b;
      funct3   = f3;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      data_a   = $urandom;
      data_b   = $urandom;
      funct3   = 3'($urandom_range(0, 7));
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] f3, input int hold);
      logic [W-1:0] exp;
      int  lat;
      bit  got;
      exp_q.push_back(model(a, b, f3));
      start_op(a, b, f3);
      check_val("in_ready_busy", {31'd0, in_ready}, 32'd0);
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check_val("out_valid_timeout", {31'd0, got}, 32'd1);
      exp = exp_q.pop_front();
      check_val("latency", lat, {24'd0, exp[11:4]});
      check_val("br_eq", {31'd0, br_eq}, {31'd0, exp[3]});
      check_val("br_lt", {31'd0, br_lt}, {31'd0, exp[2]});
      check_val("br_taken", {31'd0, br_taken}, {31'd0, exp[1]});
      check_val("br_illegal", {31'd0, br_illegal}, {31'd0, exp[0]});
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("hold_valid", {31'd0, out_valid}, 32'd1);
         check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
         check_val("hold_result", {28'd0, br_eq, br_lt, br_taken, br_illegal}, {28'd0, exp[3:0]});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check_val("release_valid", {31'd0, out_valid}, 32'd0);
      check_val("release_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic [2:0]       rf;
      bit               seen;
      tests_run    = 0;
      tests_failed = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_a    = '0;
      data_b    = '0;
      funct3    = '0;
      repeat (2) @(negedge clk);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("rst_outputs", {27'd0, out_valid, br_eq, br_lt, br_taken, br_illegal}, 32'd0);
      rst_n = 1'b1;

      run_op(32'h00000005, 32'h00000005, F3_BEQ, 0);
      run_op(32'hFFFFFFFF, 32'h00000001, F3_BLT, 0);
      run_op(32'hFFFFFFFF, 32'h00000001, F3_BLTU, 0);
      run_op(32'hFFFFFFFF, 32'h00000001, F3_BGEU, 0);
      run_op(32'h12345600, 32'h12345601, F3_BNE, 3);
      run_op(32'h00000001, 32'h00000002, 3'b010, 0);
      run_op(32'h80000000, 32'h7FFFFFFF, F3_BGE, 1);
      run_op(32'h00800000, 32'h00010000, 3'b011, 0);

      // Flush in the second CMP cycle; results of the prior op (eq=1) must clear
      run_op(32'hA5A5A5A5, 32'hA5A5A5A5, F3_BEQ, 0);
      start_op(32'h0000CAFE, 32'h0000CAFE, F3_BEQ);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check_val("flush_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("flush_outputs", {27'd0, out_valid, br_eq, br_lt, br_taken, br_illegal}, 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check_val("flush_no_valid", {31'd0, seen}, 32'd0);

      // Flush in IDLE blocks acceptance
      @(negedge clk);
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      check_val("flush_idle_block", {31'd0, in_ready}, 32'd1);

      // Reset during CMP
      run_op(32'h00000007, 32'h00000007, F3_BEQ, 0);
      start_op(32'h11111111, 32'h11111111, F3_BEQ);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("midrst_outputs", {27'd0, out_valid, br_eq, br_lt, br_taken, br_illegal}, 32'd0);

      for (int n = 0; n < 24; n++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = {ra[31:8], rb[7:0]};
            2: rb = {ra[31:16], rb[15:0]};
            default: ;
         endcase
         rf = 3'($urandom_range(0, 7));
         run_op(ra, rb, rf, $urandom_range(0, 2));
      end

      check_val("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/branch_comp_seq.md
Name: branch_comp_seq

Overview:
Parametrised, iterative successor to the combinational branch comparator, for multi-cycle and low-area cores. It accepts two WIDTH-bit operands plus the branch funct3, then compares CHUNK bits per cycle from the most significant chunk down. It stops early on the first unequal chunk and returns eq/lt/taken over a valid/ready handshake. It sits between the register-file read stage and the PC-select logic.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK (>=1).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous abort of any operation in flight
in_valid  in  1  operands/funct3 valid
in_ready  out  1  block can accept (high only in IDLE)
data_a  in  WIDTH  rs1 value
data_b  in  WIDTH  rs2 value
funct3  in  3  branch type: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
br_eq  out  1  data_a == data_b
br_lt  out  1  data_a < data_b; signed if funct3[1]=0, unsigned if funct3[1]=1
br_taken  out  1  branch condition for funct3
br_illegal  out  1  funct3 is 010 or 011

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; in_ready=1; out_valid, br_eq, br_lt, br_taken and br_illegal all 0; chunk index 0. Reset overrides flush and every handshake, including mid-operation.
- FSM IDLE -> CMP -> DONE -> IDLE.
- IDLE: in_ready=1.
  - On in_valid at edge T: latch data_a, data_b and funct3; set index to NCHUNK-1; go to CMP.
- CMP: in_ready=0, out_valid=0. Each cycle compare chunk[index] of A and B in sub-module branch_chunk_cmp.
  - Signed mode (funct3[1]=0) applies only to chunk NCHUNK-1: invert bit CHUNK-1 of both chunks, then compare unsigned.
  - If the chunks differ: br_eq<=0, br_lt<=chunk lt; go to DONE.
  - Else if index==0: br_eq<=1, br_lt<=0; go to DONE.
  - Else: decrement index and stay in CMP.
- Latency: if k chunks are examined (1..NCHUNK), out_valid is first high in cycle T+k+1. Worst case (equal operands) is NCHUNK+1 cycles after acceptance.
- br_taken, registered with the result:
  - BEQ: eq. BNE: !eq.
  - BLT/BLTU: lt. BGE/BGEU: !lt.
  - 010/011: taken=0, br_illegal=1; the comparison still runs and eq/lt are still reported.
- DONE: out_valid=1. Outputs are held stable while out_ready=0. On out_ready=1: go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
- No overlap: a new operation is accepted only from IDLE. A zero-bubble turnaround from DONE to accept is not supported.
- flush=1 at an edge in CMP or DONE: go to IDLE, clear out_valid and the result registers, drop the result.
  - In IDLE, flush blocks acceptance that cycle.
  - Flush has priority over in_valid and out_ready.
- NCHUNK=1: the single chunk is the top chunk and signed handling applies; out_valid is high at T+2.
- Input values are ignored outside the acceptance cycle. Results depend only on latched values.

Decomposition:
- Shared package branch_comp_pkg:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - State enum typedef (IDLE, CMP, DONE).
- One sub-module branch_chunk_cmp: combinational, parameter CHUNK.
  - Inputs: a, b, signed_top.
  - Outputs: lt, eq.
- Top level holds the FSM, index counter, operand/result registers and taken decode.

Test Plan (WIDTH=32, CHUNK=8):
- A=0x00000005, B=0x00000005, BEQ, accepted at T -> out_valid at T+5; eq=1, lt=0, taken=1.
- A=0xFFFFFFFF, B=0x00000001, BLT -> out_valid at T+2 (top chunk differs); lt=1, taken=1. Same operands with BLTU -> lt=0, taken=0. Same operands with BGEU -> taken=1.
- A=0x12345600, B=0x12345601, BNE -> out_valid at T+5; eq=0, lt=1, taken=1.
- Result ready with out_ready held 0 for 3 cycles -> outputs stable and in_ready=0 throughout. out_ready=1 -> IDLE next cycle; a second operation is accepted the cycle after.
- Equal operands, flush asserted in the second CMP cycle -> out_valid never rises, in_ready=1 next cycle. rst_n=0 during CMP of another operation -> all outputs 0 and in_ready=1 on the following cycle.
- funct3=010, A=1, B=2 -> br_illegal=1, taken=0, lt=1, eq=0.
